rca_serial_adder: RTL and testbench

Multi-cycle WIDTH-bit adder built around one RCA_4b instance, reused each cycle on successive 4-bit slices.
- Latches full-width operands on a START handshake.
- Feeds RCA_4b one nibble per cycle, least significant first, with a registered carry between slices.
- Assembles the WIDTH-bit SUM and final C_OUT.
- Sits directly upstream of RCA_4b and is the sequencing wrapper for wide additions that reuse the 4-bit datapath.

---
 rtl/rca_pkg.sv | 18 +
 rtl/RCA_4b.sv | 24 ++
 rtl/rca_serial_adder.sv | 115 +++++++++++
 tb/tb_rca_serial_adder.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/rca_pkg.sv
// Shared definitions for the nibble-serial adder: slice width, FSM states and
// the slice-index width helper.
package rca_pkg;

    localparam int unsigned SLICE_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Bits needed to hold a slice index 0..nslice-1, never less than one.
    function automatic int unsigned idx_w(input int unsigned nslice);
        return (nslice <= 1) ? 1 : $clog2(nslice);
    endfunction

endpackage

// File: rtl/RCA_4b.sv
// 4-bit combinational ripple-carry adder; the datapath slice that the serial
// wrapper reuses once per nibble.
module RCA_4b (
    input  logic [3:0] A,
    input  logic [3:0] B,
    input  logic       C_IN,
    output logic [3:0] SUM,
    output logic       C_OUT
);

    logic [4:0] c;

    always_comb begin
        c    = '0;
        SUM  = '0;
        c[0] = C_IN;
        for (int unsigned i = 0; i < 4; i++) begin
            SUM[i]  = A[i] ^ B[i] ^ c[i];
            c[i+1]  = (A[i] & B[i]) | (c[i] & (A[i] ^ B[i]));
        end
        C_OUT = c[4];
    end

endmodule

// File: rtl/rca_serial_adder.sv
// Multi-cycle WIDTH-bit adder feeding one RCA_4b a nibble per cycle, LSB first.
// Define RCA_SERIAL_OVF_EN to add the signed-overflow output OVF.
module rca_serial_adder
    import rca_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             START,
    input  logic [WIDTH-1:0] X,
    input  logic [WIDTH-1:0] Y,
    input  logic             C_IN,
    output logic             BUSY,
    output logic             DONE,
    output logic [WIDTH-1:0] SUM,
    output logic             C_OUT
`ifdef RCA_SERIAL_OVF_EN
    ,
    output logic             OVF
`endif
);

    localparam int unsigned NSLICE = WIDTH / SLICE_W;
    localparam int unsigned IW     = idx_w(NSLICE);
    localparam logic [IW-1:0] LAST = IW'(NSLICE - 1);

    state_t             state_q, state_d;
    logic [IW-1:0]      idx_q;
    logic               carry_q;
    logic [WIDTH-1:0]   x_lat, y_lat;
    logic [SLICE_W-1:0] slice_a, slice_b, slice_sum;
    logic               slice_co;
    logic               accept;

    assign accept = START && (state_q == ST_IDLE || state_q == ST_DONE);
    assign BUSY   = (state_q == ST_RUN);
    assign DONE   = (state_q == ST_DONE);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (START) state_d = ST_RUN;
            ST_RUN:  if (idx_q == LAST) state_d = ST_DONE;
            ST_DONE: state_d = START ? ST_RUN : ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Slice operand select: an explicit mux keeps every latched bit in use.
    always_comb begin
        slice_a = '0;
        slice_b = '0;
        for (int unsigned i = 0; i < NSLICE; i++) begin
            if (idx_q == i[IW-1:0]) begin
                slice_a = x_lat[i*SLICE_W +: SLICE_W];
                slice_b = y_lat[i*SLICE_W +: SLICE_W];
            end
        end
    end

    RCA_4b u_slice (
        .A     (slice_a),
        .B     (slice_b),
        .C_IN  (carry_q),
        .SUM   (slice_sum),
        .C_OUT (slice_co)
    );

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            idx_q   <= '0;
            carry_q <= 1'b0;
            x_lat   <= '0;
            y_lat   <= '0;
            SUM     <= '0;
            C_OUT   <= 1'b0;
`ifdef RCA_SERIAL_OVF_EN
            OVF     <= 1'b0;
`endif
        end else if (accept) begin
            x_lat   <= X;
            y_lat   <= Y;
            carry_q <= C_IN;
            idx_q   <= '0;
            SUM     <= '0;
            C_OUT   <= 1'b0;
`ifdef RCA_SERIAL_OVF_EN
            OVF     <= 1'b0;
`endif
        end else if (state_q == ST_RUN) begin
            for (int unsigned i = 0; i < NSLICE; i++) begin
                if (idx_q == i[IW-1:0]) SUM[i*SLICE_W +: SLICE_W] <= slice_sum;
            end
            carry_q <= slice_co;
            // Index wraps on the MSB slice so it never addresses past WIDTH.
            if (idx_q == LAST) begin
                idx_q <= '0;
                C_OUT <= slice_co;
`ifdef RCA_SERIAL_OVF_EN
                OVF   <= (x_lat[WIDTH-1] == y_lat[WIDTH-1]) &&
                         (slice_sum[SLICE_W-1] != x_lat[WIDTH-1]);
`endif
            end else begin
                idx_q <= idx_q + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_rca_serial_adder.sv
// Scoreboard bench for rca_serial_adder (WIDTH=16); OVF checks are compiled in
// when RCA_SERIAL_OVF_EN is defined.
module tb_rca_serial_adder;

    localparam int unsigned WIDTH  = 16;
    localparam int unsigned NSLICE = WIDTH / 4;

    logic             CLK;
    logic             RST_N;
    logic             START;
    logic [WIDTH-1:0] X, Y;
    logic             C_IN;
    logic             BUSY, DONE;
    logic [WIDTH-1:0] SUM;
    logic             C_OUT;
`ifdef RCA_SERIAL_OVF_EN
    logic             OVF;
`endif

    rca_serial_adder #(.WIDTH(WIDTH)) dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .START (START),
        .X     (X),
        .Y     (Y),
        .C_IN  (C_IN),
        .BUSY  (BUSY),
        .DONE  (DONE),
        .SUM   (SUM),
        .C_OUT (C_OUT)
`ifdef RCA_SERIAL_OVF_EN
        ,
        .OVF   (OVF)
`endif
    );

    typedef struct {
        logic [WIDTH-1:0] sum;
        logic             cout;
        logic             ovf;
        int unsigned      done_cyc;
    } exp_t;

    exp_t        sb_q[$];
    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    int unsigned cyc      = 0;
    int unsigned busy_run = 0;

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Called at a negedge; START is presented for exactly one cycle.
    task automatic start_add(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y, input logic cin);
        logic [WIDTH:0] r;
        exp_t e;
        r          = {1'b0, x} + {1'b0, y} + {{WIDTH{1'b0}}, cin};
        e.sum      = r[WIDTH-1:0];
        e.cout     = r[WIDTH];
        e.ovf      = (x[WIDTH-1] == y[WIDTH-1]) && (r[WIDTH-1] != x[WIDTH-1]);
        e.done_cyc = cyc + 1 + NSLICE;
        sb_q.push_back(e);
        X     = x;
        Y     = y;
        C_IN  = cin;
        START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
    endtask

    task automatic wait_done();
        for (int i = 0; i < 20; i++) begin
            @(negedge CLK);
            if (DONE) return;
        end
        check_eq("done_timeout", 32'(DONE), 32'd1);
    endtask

    always @(negedge CLK) begin
        exp_t e;
        if (!RST_N) begin
            busy_run = 0;
        end else begin
            if (BUSY) busy_run++;
            if (DONE) begin
                check_eq("busy_at_done", 32'(BUSY), 32'd0);
                check_eq("busy_cycles", busy_run, NSLICE);
                busy_run = 0;
                if (sb_q.size() == 0) begin
                    check_eq("sb_nonempty_at_done", sb_q.size(), 32'd1);
                end else begin
                    e = sb_q.pop_front();
                    check_eq("sum", 32'(SUM), 32'(e.sum));
                    check_eq("c_out", 32'(C_OUT), 32'(e.cout));
                    check_eq("done_latency", cyc, e.done_cyc);
`ifdef RCA_SERIAL_OVF_EN
                    check_eq("ovf", 32'(OVF), 32'(e.ovf));
`endif
                end
            end
        end
    end

    initial begin
        RST_N = 1'b0;
        START = 1'b0;
        X     = '0;
        Y     = '0;
        C_IN  = 1'b0;
        repeat (2) @(negedge CLK);
        check_eq("rst_busy", 32'(BUSY), 32'd0);
        check_eq("rst_done", 32'(DONE), 32'd0);
        check_eq("rst_sum", 32'(SUM), 32'd0);
        check_eq("rst_cout", 32'(C_OUT), 32'd0);
        RST_N = 1'b1;
        @(negedge CLK);

        start_add(16'h0000, 16'h0000, 1'b0);
        wait_done();
        @(negedge CLK);

        start_add(16'hFFFF, 16'h0001, 1'b0);
        wait_done();
        repeat (2) @(negedge CLK);
        check_eq("sum_hold_idle", 32'(SUM), 32'h0000);
        check_eq("cout_hold_idle", 32'(C_OUT), 32'd1);

        // Back-to-back: second START issued in the DONE cycle.
        start_add(16'h1234, 16'h4321, 1'b1);
        wait_done();
        start_add(16'h8000, 16'h8000, 1'b0);
        check_eq("b2b_busy", 32'(BUSY), 32'd1);
        check_eq("b2b_done_low", 32'(DONE), 32'd0);
        wait_done();
        @(negedge CLK);

        // START and operand changes during RUN must be ignored.
        start_add(16'h00F0, 16'h0010, 1'b0);
        START = 1'b1;
        X     = 16'hFFFF;
        Y     = 16'hFFFF;
        C_IN  = 1'b1;
        repeat (2) @(negedge CLK);
        START = 1'b0;
        wait_done();
        @(negedge CLK);

        // Reset abort on the second RUN cycle.
        start_add(16'hABCD, 16'h1111, 1'b0);
        @(negedge CLK);
        check_eq("mid_run_partial_sum", 32'(SUM), 32'h000E);
        RST_N = 1'b0;
        #1;
        check_eq("abort_busy", 32'(BUSY), 32'd0);
        check_eq("abort_done", 32'(DONE), 32'd0);
        check_eq("abort_sum", 32'(SUM), 32'd0);
        check_eq("abort_cout", 32'(C_OUT), 32'd0);
        sb_q.delete();
        @(negedge CLK);
        RST_N = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge CLK);
            check_eq("no_done_after_abort", 32'(DONE), 32'd0);
        end
        start_add(16'h0003, 16'h0004, 1'b0);
        wait_done();
        @(negedge CLK);

`ifdef RCA_SERIAL_OVF_EN
        start_add(16'h7FFF, 16'h0001, 1'b0);
        wait_done();
        check_eq("ovf_pos", 32'(OVF), 32'd1);
        @(negedge CLK);
        start_add(16'hFFFF, 16'h0001, 1'b0);
        wait_done();
        check_eq("ovf_neg", 32'(OVF), 32'd0);
        @(negedge CLK);
`endif

        // Random operands, alternating idle gaps and back-to-back starts.
        for (int i = 0; i < 8; i++) begin
            start_add(WIDTH'($urandom_range(0, 65535)), WIDTH'($urandom_range(0, 65535)),
                      1'($urandom_range(0, 1)));
            wait_done();
            if (i % 2 == 0) @(negedge CLK);
        end
        repeat (2) @(negedge CLK);
        check_eq("sb_drained", sb_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
